// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-enable divider
// Optional frame counter built when VGA_TIMING_FRAMECNT_EN is defined.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 10,
    parameter int FRAME_W  = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               run,
    output logic               pixEn,
    output logic               hSync,
    output logic               vSync,
    output logic               bright,
    output logic [CNT_W-1:0]   hCount,
    output logic [CNT_W-1:0]   vCount,
    output logic [CNT_W-1:0]   pixX,
    output logic [CNT_W-1:0]   pixY,
    output logic               lineStart,
    output logic               frameStart,
    output logic [FRAME_W-1:0] frameCnt
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_SYNC + H_BP + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_SYNC + V_BP + V_ACTIVE - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d;
    logic             bright_q, bright_d, line_q, line_d, frame_q, frame_d;
    logic             h_wrap, v_wrap, h_act, v_act;

    assign pixEn  = run && (div_q == DIV_MAX);
    assign h_wrap = (h_q == H_MAX);
    assign v_wrap = (v_q == V_MAX);

    // Outputs are decoded from the next-state counts so they move with the counters.
    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (run) begin
            div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        end
        if (pixEn) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
            end
        end
        line_d   = pixEn && h_wrap;
        frame_d  = line_d && v_wrap;
        h_act    = (h_d >= H_ACT_LO) && (h_d <= H_ACT_LAST);
        v_act    = (v_d >= V_ACT_LO) && (v_d <= V_ACT_LAST);
        bright_d = h_act && v_act;
        hsync_d  = (h_d < H_SYNC_END) ? HS_POL : ~HS_POL;
        vsync_d  = (v_d < V_SYNC_END) ? VS_POL : ~VS_POL;
        pix_x_d  = bright_d ? h_d - H_ACT_LO : '0;
        pix_y_d  = bright_d ? v_d - V_ACT_LO : '0;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= HS_POL;
            vsync_q  <= VS_POL;
            bright_q <= 1'b0;
            pix_x_q  <= '0;
            pix_y_q  <= '0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
            pix_x_q  <= pix_x_d;
            pix_y_q  <= pix_y_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign hSync      = hsync_q;
    assign vSync      = vsync_q;
    assign bright     = bright_q;
    assign hCount     = h_q;
    assign vCount     = v_q;
    assign pixX       = pix_x_q;
    assign pixY       = pix_y_q;
    assign lineStart  = line_q;
    assign frameStart = frame_q;

`ifdef VGA_TIMING_FRAMECNT_EN
    logic [FRAME_W-1:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            frame_cnt_q <= '0;
        end else if (frame_d) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign frameCnt = frame_cnt_q;
`else
    assign frameCnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
// Reference model tracks absolute pixel ticks since reset; raster state is derived arithmetically.
module tb_vga_timing_gen;
    localparam int CW = 10;
    localparam int FW = 8;
    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 5, S_VF = 1, S_VS = 2, S_VB = 1, S_DIV = 3;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, div;
        bit hp, vp;
    } mode_t;

    typedef struct {
        bit pix, hs, vs, br, ls, fs;
        int h, v, x, y, fc;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic run = 1'b1;
    always #5 clk = ~clk;

    logic          d_pix, d_hs, d_vs, d_br, d_ls, d_fs;
    logic [CW-1:0] d_h, d_v, d_x, d_y;
    logic [FW-1:0] d_fc;
    logic          s_pix, s_hs, s_vs, s_br, s_ls, s_fs;
    logic [CW-1:0] s_h, s_v, s_x, s_y;
    logic [FW-1:0] s_fc;

    vga_timing_gen dut_d (
        .clk(clk), .clr(clr), .run(run), .pixEn(d_pix), .hSync(d_hs), .vSync(d_vs),
        .bright(d_br), .hCount(d_h), .vCount(d_v), .pixX(d_x), .pixY(d_y),
        .lineStart(d_ls), .frameStart(d_fs), .frameCnt(d_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(S_DIV), .CNT_W(CW), .FRAME_W(FW)
    ) dut_s (
        .clk(clk), .clr(clr), .run(run), .pixEn(s_pix), .hSync(s_hs), .vSync(s_vs),
        .bright(s_br), .hCount(s_h), .vCount(s_v), .pixX(s_x), .pixY(s_y),
        .lineStart(s_ls), .frameStart(s_fs), .frameCnt(s_fc)
    );

    int     checks = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;
    longint n[2]  = '{0, 0};
    int     ph[2] = '{0, 0};
    bit     ls[2] = '{0, 0};
    bit     fs[2] = '{0, 0};

    function automatic mode_t mode_of(int m);
        mode_t p;
        if (m == 0) p = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, div:2, hp:1'b0, vp:1'b0};
        else        p = '{ha:S_HA, hf:S_HF, hs:S_HS, hb:S_HB, va:S_VA, vf:S_VF, vs:S_VS, vb:S_VB, div:S_DIV, hp:1'b1, vp:1'b1};
        return p;
    endfunction

    function automatic exp_t expect_of(int m);
        mode_t p  = mode_of(m);
        int    ht = p.hs + p.hb + p.ha + p.hf;
        int    vt = p.vs + p.vb + p.va + p.vf;
        int    h  = int'(n[m] % ht);
        int    v  = int'((n[m] / ht) % vt);
        bit    ha = (h >= p.hs + p.hb) && (h < p.hs + p.hb + p.ha);
        bit    va = (v >= p.vs + p.vb) && (v < p.vs + p.vb + p.va);
        exp_t  e;
        e.pix = run && (ph[m] == p.div - 1);
        e.h   = h;
        e.v   = v;
        e.hs  = (h < p.hs) ? p.hp : !p.hp;
        e.vs  = (v < p.vs) ? p.vp : !p.vp;
        e.br  = ha && va;
        e.x   = e.br ? h - (p.hs + p.hb) : 0;
        e.y   = e.br ? v - (p.vs + p.vb) : 0;
        e.ls  = ls[m];
        e.fs  = fs[m];
`ifdef VGA_TIMING_FRAMECNT_EN
        e.fc  = int'((n[m] / (ht * vt)) % (1 << FW));
`else
        e.fc  = 0;
`endif
        return e;
    endfunction

    function automatic exp_t act_of(int m);
        exp_t a;
        if (m == 0) begin
            a.pix = d_pix; a.hs = d_hs; a.vs = d_vs; a.br = d_br; a.ls = d_ls; a.fs = d_fs;
            a.h = int'(d_h); a.v = int'(d_v); a.x = int'(d_x); a.y = int'(d_y); a.fc = int'(d_fc);
        end else begin
            a.pix = s_pix; a.hs = s_hs; a.vs = s_vs; a.br = s_br; a.ls = s_ls; a.fs = s_fs;
            a.h = int'(s_h); a.v = int'(s_v); a.x = int'(s_x); a.y = int'(s_y); a.fc = int'(s_fc);
        end
        return a;
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cmp_all(int m);
        exp_t  e = expect_of(m);
        exp_t  a = act_of(m);
        string t = (m == 0) ? "def" : "small";
        chk({t, ".pixEn"}, a.pix, e.pix);
        chk({t, ".hSync"}, a.hs, e.hs);
        chk({t, ".vSync"}, a.vs, e.vs);
        chk({t, ".bright"}, a.br, e.br);
        chk({t, ".hCount"}, a.h, e.h);
        chk({t, ".vCount"}, a.v, e.v);
        chk({t, ".pixX"}, a.x, e.x);
        chk({t, ".pixY"}, a.y, e.y);
        chk({t, ".lineStart"}, a.ls, e.ls);
        chk({t, ".frameStart"}, a.fs, e.fs);
        chk({t, ".frameCnt"}, a.fc, e.fc);
    endtask

    // Model advances on the same edges as the DUT, using only the sampled inputs.
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            mode_t  p;
            longint nn;
            bit     tick;
            int     ht, vt;
            p    = mode_of(m);
            ht   = p.hs + p.hb + p.ha + p.hf;
            vt   = p.vs + p.vb + p.va + p.vf;
            nn   = n[m];
            tick = 1'b0;
            if (clr) begin
                ph[m] <= 0; n[m] <= 0; ls[m] <= 1'b0; fs[m] <= 1'b0;
            end else if (run) begin
                tick = (ph[m] == p.div - 1);
                if (tick) nn = nn + 1;
                ph[m] <= (ph[m] + 1) % p.div;
                n[m]  <= nn;
                ls[m] <= tick && (nn % ht == 0);
                fs[m] <= tick && (nn % (ht * vt) == 0);
            end else begin
                ls[m] <= 1'b0; fs[m] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_all(0);
            cmp_all(1);
        end
    end

    task automatic wait_for(int m, int h, int v, int budget);
        int   k = 0;
        exp_t e = expect_of(m);
        while (!(e.h == h && e.v == v) && k < budget) begin
            @(negedge clk);
            k++;
            e = expect_of(m);
        end
        chk("wait_reached", int'(e.h == h && e.v == v), 1);
    endtask

    int fc0;

    initial begin
        clr = 1'b1;
        run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst.hCount", int'(d_h), 0);
        chk("rst.vCount", int'(d_v), 0);
        chk("rst.hSync", int'(d_hs), 0);
        chk("rst.vSync", int'(d_vs), 0);
        chk("rst.bright", int'(d_br), 0);
        chk("rst.small_hSync", int'(s_hs), 1);
        chk("rst.frameCnt", int'(d_fc), 0);
        #2 clr = 1'b0;

        @(negedge clk);
        chk("first.pixEn", int'(d_pix), 1);
        chk("first.hCount0", int'(d_h), 0);
        @(negedge clk);
        chk("first.hCount1", int'(d_h), 1);
        chk("first.pixEn_low", int'(d_pix), 0);
        chk("first.small_pixEn", int'(s_pix), 1);
        chk("first.small_hCount", int'(s_h), 0);

        wait_for(0, 95, 0, 500);
        chk("hs95.hSync", int'(d_hs), 0);
        wait_for(0, 96, 0, 10);
        chk("hs96.hSync", int'(d_hs), 1);

        wait_for(0, 143, 35, 70000);
        chk("w143.bright", int'(d_br), 0);
        wait_for(0, 144, 35, 10);
        chk("w144.bright", int'(d_br), 1);
        chk("w144.pixX", int'(d_x), 0);
        chk("w144.pixY", int'(d_y), 0);
        wait_for(0, 783, 35, 2000);
        chk("w783.pixX", int'(d_x), 639);
        wait_for(0, 784, 35, 10);
        chk("w784.bright", int'(d_br), 0);
        chk("w784.pixX", int'(d_x), 0);

        wait_for(0, 300, 36, 5000);
        #2 run = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("frz.hCount", int'(d_h), 300);
            chk("frz.lineStart", int'(d_ls), 0);
            chk("frz.pixEn", int'(d_pix), 0);
        end
        #2 run = 1'b1;
        @(negedge clk);
        chk("resume.hCount", int'(d_h), 300);
        chk("resume.pixEn", int'(d_pix), 1);
        @(negedge clk);
        chk("resume.hCount_next", int'(d_h), 301);

        wait_for(1, 14, 8, 2000);
        fc0 = expect_of(1).fc;
        wait_for(1, 0, 0, 10);
        chk("wrap.hCount", int'(s_h), 0);
        chk("wrap.vCount", int'(s_v), 0);
        chk("wrap.lineStart", int'(s_ls), 1);
        chk("wrap.frameStart", int'(s_fs), 1);
`ifdef VGA_TIMING_FRAMECNT_EN
        chk("wrap.frameCnt", int'(s_fc), (fc0 + 1) % (1 << FW));
`else
        chk("wrap.frameCnt", int'(s_fc), 0);
`endif
        @(negedge clk);
        chk("wrap.lineStart_drop", int'(s_ls), 0);
        chk("wrap.frameStart_drop", int'(s_fs), 0);

        wait_for(1, 10, 4, 2000);
        #2 clr = 1'b1;
        @(negedge clk);
        chk("midrst.hCount", int'(s_h), 0);
        chk("midrst.vCount", int'(s_v), 0);
        chk("midrst.hSync", int'(s_hs), 1);
        chk("midrst.vSync", int'(s_vs), 1);
        chk("midrst.bright", int'(s_br), 0);
        chk("midrst.frameCnt", int'(s_fc), 0);
        chk("midrst.def_hCount", int'(d_h), 0);
        #2 clr = 1'b0;

        repeat (4000) begin
            @(negedge clk);
            #2;
            run = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 299) == 0);
        end
        #2 clr = 1'b0;
        run = 1'b1;
        repeat (20) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
